// File: rtl/pixel_writer.sv
// Writes SPI pixel words in raster order into a double-buffered framebuffer,
// swapping buffers on each completed frame and abandoning frames on idle timeout.
module pixel_writer #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 32,
    parameter int unsigned ADDR_BITS    = 11,
    parameter int unsigned IDLE_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          spi_data,
    input  logic                 spi_pixel_clk,
    output logic [ADDR_BITS:0]   fb_addr,
    output logic [15:0]          fb_data,
    output logic                 fb_write,
    output logic                 display_buffer,
    output logic                 frame_done,
    output logic                 sync_lost
);

    localparam int unsigned IdleBits = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [IdleBits-1:0]  IdleMax  = IdleBits'(IDLE_TIMEOUT - 1);

    localparam logic [0:0] StDiscard = 1'b0;
    localparam logic [0:0] StRun     = 1'b1;

    logic [2:0]           sync_q;
    logic                 strobe_rise;
    logic                 edge_q;
    logic [15:0]          data_q;

    logic [0:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] pix_addr_q, pix_addr_d;
    logic                 wr_buf_q, wr_buf_d;
    logic [IdleBits-1:0]  idle_cnt_q, idle_cnt_d;
    logic                 display_d;
    logic [ADDR_BITS:0]   fb_addr_d;
    logic [15:0]          fb_data_d;
    logic                 fb_write_d, frame_done_d, sync_lost_d;

    // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history.
    assign strobe_rise = sync_q[1] & ~sync_q[2];

    // spi_data is held stable by the receiver long after the strobe, so it
    // is safe to capture it unsynchronized on the detected edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
            edge_q <= 1'b0;
            data_q <= 16'h0000;
        end else begin
            sync_q <= {sync_q[1:0], spi_pixel_clk};
            edge_q <= strobe_rise;
            if (strobe_rise) begin
                data_q <= spi_data;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pix_addr_d   = pix_addr_q;
        wr_buf_d     = wr_buf_q;
        idle_cnt_d   = idle_cnt_q;
        display_d    = display_buffer;
        fb_addr_d    = fb_addr;
        fb_data_d    = fb_data;
        fb_write_d   = 1'b0;
        frame_done_d = 1'b0;
        sync_lost_d  = 1'b0;

        if (edge_q) begin
            idle_cnt_d = '0;
            if (state_q == StDiscard) begin
                state_d    = StRun;
                pix_addr_d = '0;
            end else begin
                fb_write_d = 1'b1;
                fb_addr_d  = {wr_buf_q, pix_addr_q};
                fb_data_d  = data_q;
                if (pix_addr_q == LastAddr) begin
                    pix_addr_d   = '0;
                    display_d    = wr_buf_q;
                    wr_buf_d     = ~wr_buf_q;
                    frame_done_d = 1'b1;
                end else begin
                    pix_addr_d = pix_addr_q + ADDR_BITS'(1);
                end
            end
        end else begin
            if (idle_cnt_q != IdleMax) begin
                idle_cnt_d = idle_cnt_q + IdleBits'(1);
            end
            if ((state_q == StRun) && (idle_cnt_q == IdleMax)) begin
                sync_lost_d = 1'b1;
                pix_addr_d  = '0;
                state_d     = StDiscard;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StDiscard;
            pix_addr_q     <= '0;
            wr_buf_q       <= 1'b0;
            idle_cnt_q     <= '0;
            display_buffer <= 1'b1;
            fb_addr        <= '0;
            fb_data        <= 16'h0000;
            fb_write       <= 1'b0;
            frame_done     <= 1'b0;
            sync_lost      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_addr_q     <= pix_addr_d;
            wr_buf_q       <= wr_buf_d;
            idle_cnt_q     <= idle_cnt_d;
            display_buffer <= display_d;
            fb_addr        <= fb_addr_d;
            fb_data        <= fb_data_d;
            fb_write       <= fb_write_d;
            frame_done     <= frame_done_d;
            sync_lost      <= sync_lost_d;
        end
    end

endmodule
